pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch-PC generator: the program counter register plus next-PC selection for the fetch stage.
- Adds stall hold and redirect from execute.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- Feeds instruction-memory address and prediction info down the pipeline; execute returns redirects and training updates.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded on reset (XLEN bits, word aligned).
- BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold current PC (fetch back-pressure).
- redirect_valid  in  1  execute-stage correction this cycle.
- redirect_pc  in  XLEN  corrected PC; bits [1:0] ignored.
- upd_valid  in  1  BTB training event from execute.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  XLEN  resolved target; bits [1:0] ignored.
- pc  out  XLEN  current fetch PC.
- pc_valid  out  1  pc is a real fetch address.
- pred_taken  out  1  prediction for the instruction at pc.
- pred_target  out  XLEN  predicted next PC (pc+4 when not taken).

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, pc_valid=0, pred_taken=0, pred_target=RESET_PC+4. All BTB valid bits and counters are cleared.
- pc_valid rises on the first rising edge after rst_n deasserts, then stays 1.
- Reset mid-operation discards any in-flight redirect or update.
- Index is pc[IDX+1:2] and tag is pc[XLEN-1:IDX+2], where IDX=log2(BTB_ENTRIES).
- Each BTB entry holds {valid, tag, target, ctr[1:0]}.
- Lookup is combinational on the current pc, with zero-cycle latency.
- hit = valid && tag match; pred_taken = hit && ctr[1]; pred_target = pred_taken ? target : pc+4.
- Next-PC priority at each edge:
  - 1) redirect_valid: pc <= {redirect_pc[XLEN-1:2],2'b00}. Overrides stall.
  - 2) stall: pc holds.
  - 3) otherwise: pc <= pred_target.
- pc+4 wraps modulo 2^XLEN; 0xFFFF_FFFC+4 = 0 with no flag.
- Update (upd_valid, registered, visible from the next cycle):
  - Hit, taken: ctr saturating +1 (max 3); target <= upd_target.
  - Hit, not taken: ctr saturating -1 (min 0); target kept.
  - Miss, taken: allocate or overwrite the entry: valid=1, new tag, target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents.
- Update and redirect in the same cycle are independent; both take effect.
- Stall does not block updates.

Optional Feature:
- Macro PC_GEN_BTB_EN.
- Defined: BTB is present as described above.
- Undefined: no BTB storage is instantiated. pred_taken is tied to 0 and pred_target = pc+4. Update ports are accepted and ignored. Redirect and stall behaviour are unchanged.

Decomposition:
- Package pc_gen_pkg holds:
  - the btb_entry_t struct;
  - counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - CTR_ALLOC=CTR_WT;
  - the INST_BYTES=4 constant.
- Sub-module pc_gen_btb owns storage, lookup and update. pc_gen owns the PC register and priority mux.

Test Plan:
- Reset: hold rst_n=0 3 cycles with RESET_PC=0x100 -> pc=0x100, pc_valid=0. After release: pc sequence 0x104, 0x108, ... and pc_valid=1.
- Stall vs redirect: stall=1 for 2 cycles -> pc holds. stall=1 with redirect_valid=1, redirect_pc=0x203 -> pc=0x200 next cycle.
- Training: upd pc=0x40, taken, target=0x80 -> when pc reaches 0x40, pred_taken=1, pred_target=0x80, and next pc=0x80.
- Hysteresis: after allocation (ctr=2), one not-taken update -> pred_taken=0. A further taken update -> ctr=2, pred_taken=1. Four taken updates -> ctr saturates at 3.
- Aliasing and wrap:
  - pc 0x40 and 0x440 share an index with BTB_ENTRIES=16. A taken update at 0x440 evicts 0x40, so 0x40 then predicts not taken.
  - pc=0xFFFF_FFFC with no hit -> next pc=0.
- Macro off: the training sequence of the third scenario yields pred_taken=0 always, and pc advances by 4.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the fetch-PC generator.
//   INST_BYTES   : fall-through increment between sequential fetches.
//   BTB_FIELD_W  : storage width of BTB tag/target fields (widest supported XLEN).
//   CTR_*        : 2-bit saturating direction counter encodings.
//   btb_entry_t  : one BTB entry {valid, tag, target, ctr}.
package pc_gen_pkg;

  localparam int INST_BYTES  = 4;
  localparam int BTB_FIELD_W = 64;

  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  // New entries start weakly taken so one not-taken outcome flips them.
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Tag and target are zero-extended into fixed-width fields so the type can
  // live in the package independent of XLEN / BTB_ENTRIES.
  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bus of the PC generator.
//   Inputs to pc_gen : stall, redirect_valid/redirect_pc,
//                      upd_valid/upd_pc/upd_taken/upd_target.
//   Outputs          : pc, pc_valid, pred_taken, pred_target.
// Modports: slave = the PC generator, master = the pipeline driving it.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target,
    input  pc, pc_valid, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target,
    output pc, pc_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen_btb.sv
// pc_gen_btb: direct-mapped branch target buffer with 2-bit counters.
//   clk, rst_n     : clock / async active-low reset (clears all entries).
//   lookup_pc      : current fetch PC, looked up combinationally.
//   upd_*          : training event from execute, applied at the clock edge.
//   hit_taken      : entry hits and its counter predicts taken.
//   hit_target     : stored target of the looked-up entry.
// Index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].
module pc_gen_btb
  import pc_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic            hit_taken,
  output logic [XLEN-1:0] hit_target
);
  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t             mem [BTB_ENTRIES];
  logic [IDX-1:0]         lk_idx, up_idx;
  logic [BTB_FIELD_W-1:0] lk_tag, up_tag;
  btb_entry_t             lk_e, up_e;
  logic                   up_hit;

  // Shifts (not part-selects) so tag/index derive from the whole PC word.
  assign lk_idx = IDX'(lookup_pc >> 2);
  assign lk_tag = BTB_FIELD_W'(lookup_pc >> (IDX + 2));
  assign up_idx = IDX'(upd_pc >> 2);
  assign up_tag = BTB_FIELD_W'(upd_pc >> (IDX + 2));

  // Lookup reads the registered array, so a same-cycle update to the same
  // index is only seen from the next cycle.
  assign lk_e       = mem[lk_idx];
  assign hit_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.ctr[1];
  assign hit_target = XLEN'(lk_e.target);

  assign up_e   = mem[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is small and must come out of reset with every entry
      // invalid and its counter cleared, so it is built from resettable flops
      // rather than an SRAM macro; clearing the whole entry keeps it simple.
      for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (up_e.ctr != CTR_ST) mem[up_idx].ctr <= up_e.ctr + 2'd1;
          mem[up_idx].target <= BTB_FIELD_W'(upd_target & ~XLEN'(3));
        end else if (up_e.ctr != CTR_SNT) begin
          mem[up_idx].ctr <= up_e.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Miss + taken allocates, evicting whatever aliased into this index.
        mem[up_idx] <= '{valid:  1'b1,
                         tag:    up_tag,
                         target: BTB_FIELD_W'(upd_target & ~XLEN'(3)),
                         ctr:    CTR_ALLOC};
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter register and next-PC selection.
//   clk, rst_n : clock / async active-low reset (pc <= RESET_PC, pc_valid <= 0).
//   bus        : pc_gen_if.slave carrying stall, redirect, BTB training and
//                the pc / pc_valid / pred_taken / pred_target outputs.
// Next-PC priority: redirect (overrides stall) > stall (hold) > pred_target.
// Build option: define PC_GEN_BTB_EN to include the branch target buffer;
// without it prediction is always fall-through and training is ignored.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic [XLEN-1:0] fall_through;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  // Wraps modulo 2^XLEN with no overflow indication.
  assign fall_through = pc_q + XLEN'(INST_BYTES);

`ifdef PC_GEN_BTB_EN
  logic            hit_taken;
  logic [XLEN-1:0] hit_target;

  pc_gen_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (pc_q),
    .upd_valid  (bus.upd_valid),
    .upd_pc     (bus.upd_pc),
    .upd_taken  (bus.upd_taken),
    .upd_target (bus.upd_target),
    .hit_taken  (hit_taken),
    .hit_target (hit_target)
  );

  assign pred_taken  = hit_taken;
  assign pred_target = hit_taken ? hit_target : fall_through;
`else
  assign pred_taken  = 1'b0;
  assign pred_target = fall_through;
`endif

  always_comb begin
    // NOTE: pc_d gets its default first so every path assigns it and no latch
    // is inferred; combinational logic uses blocking '=' throughout.
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = bus.redirect_pc & ~XLEN'(3);
    else if (!bus.stall)    pc_d = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking '<=' so every flop samples
      // pre-edge values regardless of statement order.
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (XLEN=32, RESET_PC=0x100,
// BTB_ENTRIES=16). Each stimulus step pushes the hand-computed state expected
// after the next rising edge; a monitor pops and compares after that edge.
module tb_pc_gen;
  localparam int XLEN = 32;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  typedef struct {
    string           name;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            pt;
    logic [XLEN-1:0] tgt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN        (XLEN),
    .RESET_PC    (32'h100),
    .BTB_ENTRIES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compares the state presented after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"},          bus.pc,                 e.pc);
        check({e.name, ".pc_valid"},    XLEN'(bus.pc_valid),    XLEN'(e.valid));
        check({e.name, ".pred_taken"},  XLEN'(bus.pred_taken),  XLEN'(e.pt));
        check({e.name, ".pred_target"}, bus.pred_target,        e.tgt);
      end
    end
  end

  // One cycle of stimulus plus the state expected after the following edge.
  task automatic step(input string name, input logic rst, input logic stall,
                      input logic rv, input logic [XLEN-1:0] rpc,
                      input logic uv, input logic [XLEN-1:0] upc,
                      input logic ut, input logic [XLEN-1:0] utgt,
                      input logic [XLEN-1:0] epc, input logic ev,
                      input logic ept, input logic [XLEN-1:0] etgt);
    exp_t e;
    @(negedge clk);
    rst_n              = rst;
    bus.stall          = stall;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    e.name = name; e.pc = epc; e.valid = ev; e.pt = ept; e.tgt = etgt;
    sb.push_back(e);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;

    //    name         rst stl rv rpc         uv upc       ut utgt      exp_pc                 v  pt   exp_tgt
    step("rst0",       0,  0,  0, 0,          0, 0,        0, 0,        32'h100,               0, 0,   32'h104);
    step("rst1",       0,  0,  0, 0,          0, 0,        0, 0,        32'h100,               0, 0,   32'h104);
    step("rst2",       0,  0,  0, 0,          0, 0,        0, 0,        32'h100,               0, 0,   32'h104);
    step("run0",       1,  0,  0, 0,          0, 0,        0, 0,        32'h104,               1, 0,   32'h108);
    step("run1",       1,  0,  0, 0,          0, 0,        0, 0,        32'h108,               1, 0,   32'h10c);
    step("run2",       1,  0,  0, 0,          0, 0,        0, 0,        32'h10c,               1, 0,   32'h110);
    step("stall0",     1,  1,  0, 0,          0, 0,        0, 0,        32'h10c,               1, 0,   32'h110);
    step("stall1",     1,  1,  0, 0,          0, 0,        0, 0,        32'h10c,               1, 0,   32'h110);
    step("stall_redir",1,  1,  1, 32'h203,    0, 0,        0, 0,        32'h200,               1, 0,   32'h204);
    step("run3",       1,  0,  0, 0,          0, 0,        0, 0,        32'h204,               1, 0,   32'h208);
    // Training: allocate 0x40 -> 0x80.
    step("train",      1,  0,  0, 0,          1, 32'h40,   1, 32'h80,   32'h208,               1, 0,   32'h20c);
    step("at40",       1,  0,  1, 32'h40,     0, 0,        0, 0,        32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("follow",     1,  0,  0, 0,          0, 0,        0, 0,        BTB ? 32'h80 : 32'h44, 1, 0,   BTB ? 32'h84 : 32'h48);
    // Hysteresis while stalled at 0x40 (updates still apply during stall).
    step("h_nt",       1,  0,  1, 32'h40,     0, 0,        0, 0,        32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_nt1",      1,  1,  0, 0,          1, 32'h40,   0, 0,        32'h40,                1, 0,   32'h44);
    step("h_t2",       1,  1,  0, 0,          1, 32'h40,   1, 32'h80,   32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_t3",       1,  1,  0, 0,          1, 32'h40,   1, 32'h80,   32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_sat_a",    1,  1,  0, 0,          1, 32'h40,   1, 32'h80,   32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_sat_b",    1,  1,  0, 0,          1, 32'h40,   1, 32'h80,   32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_dn2",      1,  1,  0, 0,          1, 32'h40,   0, 0,        32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    step("h_dn1",      1,  1,  0, 0,          1, 32'h40,   0, 0,        32'h40,                1, 0,   32'h44);
    step("h_up2",      1,  1,  0, 0,          1, 32'h40,   1, 32'h80,   32'h40,                1, BTB, BTB ? 32'h80 : 32'h44);
    // Same-cycle lookup/update: prediction uses pre-update contents.
    step("same_nt",    1,  0,  0, 0,          1, 32'h40,   0, 0,        BTB ? 32'h80 : 32'h44, 1, 0,   BTB ? 32'h84 : 32'h48);
    step("re40_a",     1,  0,  1, 32'h40,     0, 0,        0, 0,        32'h40,                1, 0,   32'h44);
    step("same_t",     1,  0,  0, 0,          1, 32'h40,   1, 32'h90,   32'h44,                1, 0,   32'h48);
    step("re40_b",     1,  0,  1, 32'h40,     0, 0,        0, 0,        32'h40,                1, BTB, BTB ? 32'h90 : 32'h44);
    // Aliasing: 0x440 shares index 0 with 0x40 and evicts it.
    step("alias_upd",  1,  1,  0, 0,          1, 32'h440,  1, 32'h500,  32'h40,                1, 0,   32'h44);
    step("at440",      1,  0,  1, 32'h440,    0, 0,        0, 0,        32'h440,               1, BTB, BTB ? 32'h500 : 32'h444);
    step("follow440",  1,  0,  0, 0,          0, 0,        0, 0,        BTB ? 32'h500 : 32'h444, 1, 0, BTB ? 32'h504 : 32'h448);
    // Wrap at the top of the address space; redirect low bits ignored.
    step("top",        1,  0,  1, 32'hFFFF_FFFE, 0, 0,     0, 0,        32'hFFFF_FFFC,         1, 0,   32'h0);
    step("wrap",       1,  0,  0, 0,          0, 0,        0, 0,        32'h0,                 1, 0,   32'h4);
    // Reset mid-operation discards a concurrent redirect and update.
    step("mid_rst0",   0,  0,  1, 32'h300,    1, 32'h0,    1, 32'h600,  32'h100,               0, 0,   32'h104);
    step("mid_rst1",   0,  0,  0, 0,          0, 0,        0, 0,        32'h100,               0, 0,   32'h104);
    step("post_rst",   1,  0,  0, 0,          0, 0,        0, 0,        32'h104,               1, 0,   32'h108);
    step("post440",    1,  0,  1, 32'h440,    0, 0,        0, 0,        32'h440,               1, 0,   32'h444);
    step("post0",      1,  0,  1, 32'h0,      0, 0,        0, 0,        32'h0,                 1, 0,   32'h4);

    @(negedge clk);
    bus.redirect_valid = 1'b0;
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    stim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
